// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - CDB arbiter request/broadcast bundle
// master: execution-unit side driving requests; slave: the arbiter.
interface cdb_arbiter_if #(
  parameter int NUM_UNITS = 4,
  parameter int TAG_W     = 5,
  parameter int DATA_W    = 32
);
  logic [NUM_UNITS-1:0]        in_req;
  logic [NUM_UNITS*TAG_W-1:0]  in_tag;
  logic [NUM_UNITS*DATA_W-1:0] in_val;
  logic [NUM_UNITS-1:0]        in_icc_valid;
  logic [NUM_UNITS*4-1:0]      in_icc;
  logic [NUM_UNITS-1:0]        out_ack;
  logic                        out_CDB_broadcast;
  logic [TAG_W-1:0]            out_CDB_tag;
  logic [DATA_W-1:0]           out_CDB_val;
  logic                        out_ICC_we;
  logic [3:0]                  out_ICC_flags;
  logic                        out_drop_err;

  modport master (
    output in_req, in_tag, in_val, in_icc_valid, in_icc,
    input  out_ack, out_CDB_broadcast, out_CDB_tag, out_CDB_val,
           out_ICC_we, out_ICC_flags, out_drop_err
  );

  modport slave (
    input  in_req, in_tag, in_val, in_icc_valid, in_icc,
    output out_ack, out_CDB_broadcast, out_CDB_tag, out_CDB_val,
           out_ICC_we, out_ICC_flags, out_drop_err
  );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin Common Data Bus arbiter
// One registered stage: grant, broadcast and ICC forwarding all come from flops.
module cdb_arbiter #(
  parameter int                 NUM_UNITS   = 4,
  parameter int                 TAG_W       = 5,
  parameter int                 DATA_W      = 32,
  parameter logic [TAG_W-1:0]   INVALID_TAG = {TAG_W{1'b1}}
) (
  input  logic            clk,
  input  logic            rst_n,
  cdb_arbiter_if.slave    bus
);
  localparam int PTR_W = $clog2(NUM_UNITS);

  logic [PTR_W-1:0]     rr_ptr;
  logic [NUM_UNITS-1:0] eff_req;
  logic                 grant_found;
  logic [PTR_W-1:0]     grant_idx;
  int                   cand;
  logic [TAG_W-1:0]     sel_tag;
  logic [DATA_W-1:0]    sel_val;
  logic [3:0]           sel_icc;
  logic                 sel_icc_valid;

  // A unit being acked this cycle may still hold req; mask it to avoid a double grant.
  assign eff_req = bus.in_req & ~bus.out_ack;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_UNITS) cand = cand - NUM_UNITS;
      if (!grant_found && eff_req[cand]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(cand);
      end
    end
  end

  assign sel_tag       = bus.in_tag[int'(grant_idx)*TAG_W +: TAG_W];
  assign sel_val       = bus.in_val[int'(grant_idx)*DATA_W +: DATA_W];
  assign sel_icc       = bus.in_icc[int'(grant_idx)*4 +: 4];
  assign sel_icc_valid = bus.in_icc_valid[grant_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr                <= '0;
      bus.out_ack           <= '0;
      bus.out_CDB_broadcast <= 1'b0;
      bus.out_CDB_tag       <= INVALID_TAG;
      bus.out_CDB_val       <= '0;
      bus.out_ICC_we        <= 1'b0;
      bus.out_ICC_flags     <= 4'b0;
      bus.out_drop_err      <= 1'b0;
    end else if (grant_found) begin
      bus.out_ack <= NUM_UNITS'(1) << grant_idx;
      rr_ptr      <= (grant_idx == PTR_W'(NUM_UNITS-1)) ? '0 : grant_idx + 1'b1;
      if (sel_tag != INVALID_TAG) begin
        bus.out_CDB_broadcast <= 1'b1;
        bus.out_CDB_tag       <= sel_tag;
        bus.out_CDB_val       <= sel_val;
        bus.out_ICC_we        <= sel_icc_valid;
        if (sel_icc_valid) bus.out_ICC_flags <= sel_icc;
      end else begin
        // Dropped producer: ack frees the unit, nothing reaches the bus.
        bus.out_CDB_broadcast <= 1'b0;
        bus.out_ICC_we        <= 1'b0;
        bus.out_drop_err      <= 1'b1;
      end
    end else begin
      bus.out_ack           <= '0;
      bus.out_CDB_broadcast <= 1'b0;
      bus.out_ICC_we        <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed self-checking bench for cdb_arbiter
// Hand-computed vectors; outputs sampled 1ns after the rising edge.
module tb_cdb_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  cdb_arbiter_if #(.NUM_UNITS(4), .TAG_W(5), .DATA_W(32)) bus ();

  cdb_arbiter #(.NUM_UNITS(4), .TAG_W(5), .DATA_W(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_unit(input int k, input logic req, input logic [4:0] tag,
                          input logic [31:0] val, input logic iccv, input logic [3:0] icc);
    bus.in_req[k]         = req;
    bus.in_tag[k*5 +: 5]  = tag;
    bus.in_val[k*32 +: 32] = val;
    bus.in_icc_valid[k]   = iccv;
    bus.in_icc[k*4 +: 4]  = icc;
  endtask

  task automatic clear_all();
    for (int k = 0; k < 4; k++) set_unit(k, 1'b0, 5'd0, 32'd0, 1'b0, 4'd0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    clear_all();
    for (int k = 0; k < 4; k++) set_unit(k, 1'b1, 5'(k), 32'(100 + k), 1'b0, 4'd0);

    // Reset values with every unit requesting
    tick();
    tick();
    chk("rst_ack",   64'(bus.out_ack), 64'h0);
    chk("rst_bcast", 64'(bus.out_CDB_broadcast), 64'h0);
    chk("rst_tag",   64'(bus.out_CDB_tag), 64'h1f);
    chk("rst_val",   64'(bus.out_CDB_val), 64'h0);
    chk("rst_we",    64'(bus.out_ICC_we), 64'h0);
    chk("rst_flags", 64'(bus.out_ICC_flags), 64'h0);
    chk("rst_drop",  64'(bus.out_drop_err), 64'h0);
    rst_n = 1'b1;
    tick();
    chk("first_ack",   64'(bus.out_ack), 64'h1);
    chk("first_tag",   64'(bus.out_CDB_tag), 64'h0);
    chk("first_bcast", 64'(bus.out_CDB_broadcast), 64'h1);
    chk("first_val",   64'(bus.out_CDB_val), 64'd100);

    // Single request from unit 2
    clear_all();
    pulse_reset();
    set_unit(2, 1'b1, 5'd2, 32'h0000_0007, 1'b1, 4'b0010);
    tick();
    chk("single_bcast", 64'(bus.out_CDB_broadcast), 64'h1);
    chk("single_tag",   64'(bus.out_CDB_tag), 64'h2);
    chk("single_val",   64'(bus.out_CDB_val), 64'h7);
    chk("single_we",    64'(bus.out_ICC_we), 64'h1);
    chk("single_flags", 64'(bus.out_ICC_flags), 64'h2);
    chk("single_ack",   64'(bus.out_ack), 64'h4);
    set_unit(2, 1'b0, 5'd2, 32'h0000_0007, 1'b1, 4'b0010);
    tick();
    chk("single_idle_bcast", 64'(bus.out_CDB_broadcast), 64'h0);
    chk("single_idle_ack",   64'(bus.out_ack), 64'h0);
    chk("single_idle_we",    64'(bus.out_ICC_we), 64'h0);
    chk("single_hold_tag",   64'(bus.out_CDB_tag), 64'h2);
    chk("single_hold_flags", 64'(bus.out_ICC_flags), 64'h2);

    // Round-robin with all four units requesting continuously
    pulse_reset();
    for (int k = 0; k < 4; k++) set_unit(k, 1'b1, 5'(10 + k), 32'(200 + k), 1'b0, 4'hf);
    for (int n = 0; n < 6; n++) begin
      tick();
      chk($sformatf("rr%0d_ack", n),   64'(bus.out_ack), 64'(1 << (n % 4)));
      chk($sformatf("rr%0d_tag", n),   64'(bus.out_CDB_tag), 64'(10 + (n % 4)));
      chk($sformatf("rr%0d_bcast", n), 64'(bus.out_CDB_broadcast), 64'h1);
    end
    chk("rr_we",    64'(bus.out_ICC_we), 64'h0);
    chk("rr_flags", 64'(bus.out_ICC_flags), 64'h0);

    // Ack masking: unit 1 holds req through its ack cycle, unit 3 also requests
    clear_all();
    pulse_reset();
    set_unit(1, 1'b1, 5'd1, 32'd11, 1'b0, 4'd0);
    set_unit(3, 1'b1, 5'd3, 32'd33, 1'b0, 4'd0);
    tick();
    chk("mask_a_ack0", 64'(bus.out_ack), 64'h2);
    tick();
    chk("mask_a_ack1", 64'(bus.out_ack), 64'h8);
    chk("mask_a_tag1", 64'(bus.out_CDB_tag), 64'h3);
    clear_all();
    tick();
    chk("mask_a_idle", 64'(bus.out_ack), 64'h0);

    // Ack masking with unit 1 alone: the held req must not be granted again
    pulse_reset();
    set_unit(1, 1'b1, 5'd1, 32'd11, 1'b0, 4'd0);
    tick();
    chk("mask_b_ack0", 64'(bus.out_ack), 64'h2);
    tick();
    chk("mask_b_ack1",   64'(bus.out_ack), 64'h0);
    chk("mask_b_bcast1", 64'(bus.out_CDB_broadcast), 64'h0);
    clear_all();

    // Invalid tag is acked and dropped; error flag is sticky
    pulse_reset();
    set_unit(0, 1'b1, 5'h1f, 32'hdead, 1'b1, 4'b1111);
    tick();
    chk("inv_ack",   64'(bus.out_ack), 64'h1);
    chk("inv_bcast", 64'(bus.out_CDB_broadcast), 64'h0);
    chk("inv_we",    64'(bus.out_ICC_we), 64'h0);
    chk("inv_drop",  64'(bus.out_drop_err), 64'h1);
    chk("inv_flags", 64'(bus.out_ICC_flags), 64'h0);
    clear_all();
    set_unit(2, 1'b1, 5'd4, 32'd44, 1'b0, 4'd0);
    tick();
    chk("inv_next_bcast", 64'(bus.out_CDB_broadcast), 64'h1);
    chk("inv_next_tag",   64'(bus.out_CDB_tag), 64'h4);
    chk("inv_sticky",     64'(bus.out_drop_err), 64'h1);
    clear_all();
    tick();
    chk("inv_sticky_idle", 64'(bus.out_drop_err), 64'h1);
    pulse_reset();
    chk("inv_cleared", 64'(bus.out_drop_err), 64'h0);

    // Reset mid-stream drops the strobe without a clock edge
    for (int k = 0; k < 4; k++) set_unit(k, 1'b1, 5'(20 + k), 32'(300 + k), 1'b0, 4'd0);
    tick();
    chk("mid_pre_bcast", 64'(bus.out_CDB_broadcast), 64'h1);
    tick();
    chk("mid_pre_ack", 64'(bus.out_ack), 64'h2);
    rst_n = 1'b0;
    #1;
    chk("mid_async_bcast", 64'(bus.out_CDB_broadcast), 64'h0);
    chk("mid_async_ack",   64'(bus.out_ack), 64'h0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("mid_restart_ack", 64'(bus.out_ack), 64'h1);
    chk("mid_restart_tag", 64'(bus.out_CDB_tag), 64'd20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common Data Bus (CDB) arbiter for the Tomasulo core. It collects completion requests from up to `NUM_UNITS` reservation-station execution units (ADD, LOGIC, SHIFT, MEM, ...). It grants exactly one request per cycle using round-robin order, and drives the single CDB broadcast that every reservation station and the register-status table snoop. It also forwards integer condition codes (ICC) from the granted result to the PSR write port.

## Interface

Parameters:
- `NUM_UNITS`, default 4: number of requesting execution units (2..8).
- `TAG_W`, default 5: reservation-station tag width.
- `DATA_W`, default 32: result width.
- `INVALID_TAG`, default 5'b11111: reserved "no producer" tag; never broadcast.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_req` in NUM_UNITS: per-unit request; level; held until acked.
- `in_tag` in NUM_UNITS*TAG_W: per-unit producing tag. Unit k uses slice [k*TAG_W +: TAG_W].
- `in_val` in NUM_UNITS*DATA_W: per-unit result value.
- `in_icc_valid` in NUM_UNITS: the unit's result updates condition codes (a *_CC opcode).
- `in_icc` in NUM_UNITS*4: per-unit flags {c,v,z,n}.
- `out_ack` out NUM_UNITS: one-hot, one-cycle pulse telling the unit its request was consumed.
- `out_CDB_broadcast` out 1: one-cycle valid strobe for the CDB.
- `out_CDB_tag` out TAG_W: broadcast tag.
- `out_CDB_val` out DATA_W: broadcast value.
- `out_ICC_we` out 1: PSR ICC write enable, coincident with the broadcast.
- `out_ICC_flags` out 4: {c,v,z,n} for the PSR.
- `out_drop_err` out 1: sticky flag; set when an INVALID_TAG request is dropped.

## Operation

- Single state element set: round-robin pointer `rr_ptr` (log2 NUM_UNITS bits), registered outputs, sticky error.
- Each cycle, the arbiter evaluates `in_req`.
  - Winner = first asserted request at or after `rr_ptr`, wrapping modulo NUM_UNITS.
  - No request: no grant; `rr_ptr` unchanged.
- On a grant to unit k:
  - Next edge: `out_ack[k]`=1 for exactly one cycle.
  - `rr_ptr` <= (k+1) mod NUM_UNITS.
- If the winner's tag != INVALID_TAG:
  - Next edge: `out_CDB_broadcast`=1, `out_CDB_tag`/`out_CDB_val` = unit k's tag/value.
  - `out_ICC_we` = `in_icc_valid[k]`; `out_ICC_flags` = `in_icc[k]` when the write enable is set, otherwise held at its previous value.
- If the winner's tag == INVALID_TAG:
  - Unit is acked (so it frees itself), but there is no broadcast and no ICC write.
  - `out_drop_err` <= 1; it stays set until reset.
- Outputs with no grant:
  - `out_CDB_broadcast`, `out_ICC_we`, `out_ack` = 0.
  - Tag/value hold their last broadcast contents; consumers use only the strobe.
- Unit contract:
  - Req, tag, val and icc stay stable from req assertion until the cycle after `out_ack`.
  - A unit may re-assert req in the cycle immediately after its ack.
  - A req still high in the ack cycle itself is ignored, to prevent a double grant: the arbiter masks unit k for the cycle in which `out_ack[k]`=1.
- Reset (asynchronous assert, synchronous deassert by the surrounding logic):
  - `rr_ptr`=0; `out_ack`=0; `out_CDB_broadcast`=0; `out_CDB_tag`=INVALID_TAG; `out_CDB_val`=0; `out_ICC_we`=0; `out_ICC_flags`=0; `out_drop_err`=0.
  - Reset mid-broadcast kills the strobe immediately. A pending grant is lost, and the unit re-requests after reset.

## Timing

- Latency: req sampled at edge N -> broadcast and ack are valid during cycle N+1. This is a single registered stage, and all outputs come directly from flops.
- Throughput: one broadcast per cycle when requests are continuous.
- Fairness: any unit holding req is granted within NUM_UNITS cycles.
- Simultaneous requests from all units: grants go out in rotation starting at `rr_ptr`, one per cycle, with no idle cycles.
- Wrap-around: a grant to unit NUM_UNITS-1 sets `rr_ptr`=0.
- Consumers see the strobe for exactly one cycle. Back-to-back broadcasts appear as a strobe held high across consecutive cycles with differing tags.

## Test plan

- Reset values: hold `rst_n`=0, with all `in_req`=1 and tags 0..3 -> all outputs at their reset values, and `out_CDB_tag`=5'b11111. After release, the first broadcast is tag 0 from unit 0.
- Single request: unit 2 requests with tag 2, val 32'h0000_0007, icc_valid=1, icc=4'b0010 -> next cycle: broadcast=1, tag=2, val=7, ICC_we=1, flags=4'b0010, ack=4'b0100. Broadcast=0 the following cycle.
- Round-robin: all four units request continuously and re-request after each ack -> grant order 0,1,2,3,0,1 on consecutive cycles, with the strobe high every cycle.
- Ack masking: unit 1 holds req one cycle past its ack, with unit 3 also requesting -> unit 1 is not granted twice; the order is 1,3.
- Invalid tag: unit 0 requests with tag 5'b11111 -> ack[0]=1, broadcast=0, ICC_we=0, drop_err=1, and drop_err stays 1 until reset.
- Reset mid-stream: assert `rst_n`=0 asynchronously while broadcast=1 -> the strobe drops without waiting for a clock edge, and `rr_ptr` restarts at 0.
